// File: rtl/counter_updown_pkg.sv
// Shared encodings for the up/down counter step scheduler: FSM states,
// requester identities and counting directions.
package counter_updown_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } sched_state_t;

    localparam logic OWNER_A  = 1'b0;
    localparam logic OWNER_B  = 1'b1;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_updown_sched_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant plus the "last served"
// pointer, which only moves when the scheduler finishes a job.
module rr_arbiter2
    import counter_updown_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic upd,
    input  logic upd_owner,
    output logic gnt_a,
    output logic gnt_b
);

    logic ptr;

    // On a tie the requester that was not served last wins.
    assign gnt_a = req_a & (~req_b | (ptr == OWNER_B));
    assign gnt_b = req_b & ~gnt_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= OWNER_B;
        end else if (upd) begin
            ptr <= upd_owner;
        end
    end

endmodule

// File: rtl/counter_updown_sched.sv
// Step scheduler for the 3-bit up/down counter: arbitrates two job requesters
// and emits paced step pulses. Optional abort input under SCHED_ABORT_EN.
module counter_updown_sched
    import counter_updown_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a_valid,
    input  logic             req_a_dir,
    input  logic [WIDTH-1:0] req_a_steps,
    output logic             req_a_ready,
    input  logic             req_b_valid,
    input  logic             req_b_dir,
    input  logic [WIDTH-1:0] req_b_steps,
    output logic             req_b_ready,
    input  logic [DIV_W-1:0] interval,
    output logic             cnt_en,
    output logic             cnt_dir,
    output logic             busy,
    output logic             owner,
    output logic [WIDTH-1:0] steps_left,
    output logic             done
`ifdef SCHED_ABORT_EN
    ,
    input  logic             abort
`endif
);

    sched_state_t     state, nstate;
    logic [DIV_W-1:0] timer;
    logic [DIV_W-1:0] intv_r;
    logic             gnt_a, gnt_b;
    logic             accept;
    logic             abort_w;
    logic             sel_dir;
    logic [WIDTH-1:0] sel_steps;

`ifdef SCHED_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a_valid),
        .req_b     (req_b_valid),
        .upd       (state == DONE),
        .upd_owner (owner),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b)
    );

    assign sel_dir     = gnt_b ? req_b_dir   : req_a_dir;
    assign sel_steps   = gnt_b ? req_b_steps : req_a_steps;
    // Ready is gated by rst so it reads 0 while reset is held.
    assign req_a_ready = (state == IDLE) & gnt_a & ~rst;
    assign req_b_ready = (state == IDLE) & gnt_b & ~rst;
    assign busy        = (state != IDLE);

    always_comb begin
        nstate = state;
        accept = 1'b0;
        cnt_en = 1'b0;
        done   = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_a | gnt_b) begin
                    accept = 1'b1;
                    nstate = (sel_steps == '0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (abort_w)           nstate = DONE;
                else if (timer == '0)  nstate = STEP;
            end
            STEP: begin
                if (abort_w) begin
                    nstate = DONE;
                end else begin
                    cnt_en = 1'b1;
                    nstate = (steps_left == WIDTH'(1)) ? DONE : WAIT;
                end
            end
            DONE: begin
                done   = 1'b1;
                nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            intv_r     <= '0;
            cnt_dir    <= 1'b0;
            owner      <= 1'b0;
            steps_left <= '0;
        end else begin
            state <= nstate;
            if (accept) begin
                cnt_dir    <= sel_dir;
                steps_left <= sel_steps;
                timer      <= interval;
                intv_r     <= interval;
                owner      <= gnt_b;
            end else if (state == WAIT && !abort_w && timer != '0) begin
                timer <= timer - DIV_W'(1);
            end else if (cnt_en) begin
                // Reload for the next gap; on the final step this is harmless.
                steps_left <= steps_left - WIDTH'(1);
                timer      <= intv_r;
            end
        end
    end

endmodule

// File: tb/tb_counter_updown_sched.sv
// Directed bench for counter_updown_sched with a small 3-bit counter model
// fed by cnt_en/cnt_dir. Abort scenario is built when SCHED_ABORT_EN is set.
module tb_counter_updown_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a_valid = 1'b0, req_a_dir = 1'b0;
    logic [2:0] req_a_steps = '0;
    logic       req_a_ready;
    logic       req_b_valid = 1'b0, req_b_dir = 1'b0;
    logic [2:0] req_b_steps = '0;
    logic       req_b_ready;
    logic [3:0] interval = '0;
    logic       cnt_en, cnt_dir, busy, owner, done;
    logic [2:0] steps_left;
    logic       abort = 1'b0;
    logic       ctr_clr = 1'b0;
    logic [2:0] ctr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    counter_updown_sched #(.WIDTH(3), .DIV_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_a_valid (req_a_valid),
        .req_a_dir   (req_a_dir),
        .req_a_steps (req_a_steps),
        .req_a_ready (req_a_ready),
        .req_b_valid (req_b_valid),
        .req_b_dir   (req_b_dir),
        .req_b_steps (req_b_steps),
        .req_b_ready (req_b_ready),
        .interval    (interval),
        .cnt_en      (cnt_en),
        .cnt_dir     (cnt_dir),
        .busy        (busy),
        .owner       (owner),
        .steps_left  (steps_left),
        .done        (done)
`ifdef SCHED_ABORT_EN
        ,
        .abort       (abort)
`endif
    );

    // Reference counter the scheduler is meant to drive.
    always_ff @(posedge clk) begin
        if (ctr_clr)     ctr <= '0;
        else if (cnt_en) ctr <= cnt_dir ? ctr + 3'd1 : ctr - 3'd1;
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Single-requester job; cycle 0 is the accept cycle.
    task automatic run_job(input string nm, input logic use_b, input logic dir,
                           input int steps, input int intv, input int exp_pulses,
                           input int exp_done, input int exp_ctr);
        int pulses = 0;
        logic exp_en;
        ctr_clr = 1'b1;
        step();
        ctr_clr = 1'b0;
        interval = 4'(intv);
        if (use_b) begin
            req_b_valid = 1'b1; req_b_dir = dir; req_b_steps = 3'(steps);
        end else begin
            req_a_valid = 1'b1; req_a_dir = dir; req_a_steps = 3'(steps);
        end
        #1;
        chk({nm, " ready_a"}, int'(req_a_ready), int'(!use_b));
        chk({nm, " ready_b"}, int'(req_b_ready), int'(use_b));
        for (int c = 0; c <= exp_done + 1; c++) begin
            if (c > 0) begin
                step();
                if (c == 1) begin
                    req_a_valid = 1'b0; req_b_valid = 1'b0;
                    interval = 4'hf; req_a_dir = ~dir; req_b_dir = ~dir;
                end
                #1;
            end
            exp_en = (c > 0) && (c % (intv + 2) == 0) && (c / (intv + 2) <= steps);
            if (cnt_en) pulses++;
            chk($sformatf("%s en c%0d", nm, c), int'(cnt_en), int'(exp_en));
            chk($sformatf("%s done c%0d", nm, c), int'(done), int'(c == exp_done));
            if (c >= 1) chk($sformatf("%s dir c%0d", nm, c), int'(cnt_dir), int'(dir));
        end
        chk({nm, " pulses"}, pulses, exp_pulses);
        chk({nm, " busy_end"}, int'(busy), 0);
        chk({nm, " counter"}, int'(ctr), exp_ctr);
        chk({nm, " owner"}, int'(owner), int'(use_b));
        chk({nm, " steps_left_end"}, int'(steps_left), 0);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int pulses;
        // Reset state
        #1;
        chk("rst cnt_en", int'(cnt_en), 0);
        chk("rst cnt_dir", int'(cnt_dir), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst owner", int'(owner), 0);
        chk("rst steps_left", int'(steps_left), 0);
        chk("rst done", int'(done), 0);
        chk("rst ready_a", int'(req_a_ready), 0);
        chk("rst ready_b", int'(req_b_ready), 0);
        step();
        rst = 1'b0;
        step();

        run_job("a_up3", 1'b0, 1'b1, 3, 1, 3, 10, 3);

        // Round-robin tie handling from a fresh reset.
        do_reset();
        step();
        interval = 4'd0;
        req_a_valid = 1'b1; req_a_dir = 1'b1; req_a_steps = 3'd1;
        req_b_valid = 1'b1; req_b_dir = 1'b0; req_b_steps = 3'd1;
        #1;
        chk("tie1 ready_a", int'(req_a_ready), 1);
        chk("tie1 ready_b", int'(req_b_ready), 0);
        step(); req_a_valid = 1'b0; #1;
        chk("tie1 owner", int'(owner), 0);
        chk("tie1 dir", int'(cnt_dir), 1);
        chk("tie1 steps_left", int'(steps_left), 1);
        chk("tie1 b_waits", int'(req_b_ready), 0);
        step(); #1;
        chk("tie1 pulse", int'(cnt_en), 1);
        step(); #1;
        chk("tie1 done", int'(done), 1);
        step(); req_a_valid = 1'b1; #1;
        chk("tie2 ready_b", int'(req_b_ready), 1);
        chk("tie2 ready_a", int'(req_a_ready), 0);
        step(); req_b_valid = 1'b0; #1;
        chk("tie2 owner", int'(owner), 1);
        chk("tie2 dir", int'(cnt_dir), 0);
        step(); #1;
        chk("tie2 pulse", int'(cnt_en), 1);
        step(); #1;
        chk("tie2 done", int'(done), 1);
        step(); req_b_valid = 1'b1; #1;
        chk("tie3 ready_a", int'(req_a_ready), 1);
        chk("tie3 ready_b", int'(req_b_ready), 0);
        step(); req_a_valid = 1'b0; req_b_valid = 1'b0;
        step(); step(); step(); #1;
        chk("tie3 idle", int'(busy), 0);
        chk("tie3 owner", int'(owner), 0);

        run_job("b_zero", 1'b1, 1'b1, 0, 2, 0, 1, 0);
        run_job("a_dn7", 1'b0, 1'b0, 7, 0, 7, 15, 1);

        // Asynchronous reset in the middle of a WAIT gap.
        step();
        interval = 4'd5;
        req_a_valid = 1'b1; req_a_dir = 1'b1; req_a_steps = 3'd3;
        #1;
        chk("rstw accept", int'(req_a_ready), 1);
        step(); req_a_valid = 1'b0;
        step(); #1;
        chk("rstw steps_left", int'(steps_left), 3);
        chk("rstw busy", int'(busy), 1);
        rst = 1'b1; req_a_valid = 1'b1; #1;
        chk("rstw cnt_en", int'(cnt_en), 0);
        chk("rstw busy0", int'(busy), 0);
        chk("rstw done", int'(done), 0);
        chk("rstw steps0", int'(steps_left), 0);
        chk("rstw dir0", int'(cnt_dir), 0);
        chk("rstw ready0", int'(req_a_ready), 0);
        req_a_valid = 1'b0;
        step();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (cnt_en) pulses++;
        end
        chk("rstw no_pulse", pulses, 0);
        chk("rstw idle", int'(busy), 0);

`ifdef SCHED_ABORT_EN
        // Abort during the gap after the first pulse.
        step();
        interval = 4'd3;
        req_a_valid = 1'b1; req_a_dir = 1'b1; req_a_steps = 3'd5;
        #1;
        chk("abt accept", int'(req_a_ready), 1);
        step(); req_a_valid = 1'b0;
        for (int c = 2; c <= 5; c++) step();
        #1;
        chk("abt pulse1", int'(cnt_en), 1);
        step(); abort = 1'b1; #1;
        chk("abt en_forced", int'(cnt_en), 0);
        step(); abort = 1'b0; #1;
        chk("abt done", int'(done), 1);
        chk("abt steps_left", int'(steps_left), 4);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (cnt_en) pulses++;
        end
        chk("abt no_pulse", pulses, 0);
        chk("abt idle", int'(busy), 0);
        chk("abt steps_hold", int'(steps_left), 4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
